rv_alu: RTL and testbench

//  RV32 integer execute-stage ALU, RV32I plus MUL.

---
 rtl/rv_pkg.sv | 43 ++++
 rtl/rv_alu_decode.sv | 37 +++
 rtl/rv_alu.sv | 61 ++++++
 tb/tb_rv_alu.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 opcode/funct codes, exception codes and the ALU op enum.
package rv_pkg;
    localparam logic [6:0] OPCODE_ALU     = 7'b0110011;
    localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPCODE_JUMP    = 7'b1101111;

    localparam logic [6:0] ADD_OR_AND_FUNCT7 = 7'b0000000;
    localparam logic [6:0] SUB_FUNCT7        = 7'b0100000;
    localparam logic [6:0] MUL_FUNCT7        = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [31:0] EXC_NONE           = 32'd0;
    localparam logic [31:0] EXC_ILLEGAL_OPCODE = 32'd1;
    localparam logic [31:0] EXC_ILLEGAL_FUNCT  = 32'd2;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
        OP_SRA, OP_OR, OP_AND, OP_MUL, OP_BR, OP_JMP
    } alu_op_t;

    // funct3 mapping shared by register and immediate forms (shift right = logical)
    function automatic alu_op_t base_op(input logic [2:0] f3);
        case (f3)
            F3_SLL:  return OP_SLL;
            F3_SLT:  return OP_SLT;
            F3_SLTU: return OP_SLTU;
            F3_XOR:  return OP_XOR;
            F3_SR:   return OP_SRL;
            F3_OR:   return OP_OR;
            F3_AND:  return OP_AND;
            default: return OP_ADD;
        endcase
    endfunction
endpackage

// File: rtl/rv_alu_decode.sv
// rv_alu_decode: opcode/funct7/funct3 -> ALU op and exception code.
//   opcode, funct7, funct3 : instruction fields
//   op                     : selected ALU operation
//   exc                    : 0 none, 1 illegal opcode, 2 illegal funct
module rv_alu_decode
    import rv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [6:0]  funct7,
    input  logic [2:0]  funct3,
    output alu_op_t     op,
    output logic [31:0] exc
);
    always_comb begin
        op  = OP_ADD;
        exc = EXC_NONE;
        case (opcode)
            OPCODE_ALU: begin
                if (funct7 == ADD_OR_AND_FUNCT7) op = base_op(funct3);
                else if (funct7 == SUB_FUNCT7 && funct3 == F3_ADD) op = OP_SUB;
                else if (funct7 == SUB_FUNCT7 && funct3 == F3_SR) op = OP_SRA;
                else if (funct7 == MUL_FUNCT7 && funct3 == F3_ADD) op = OP_MUL;
                else exc = EXC_ILLEGAL_FUNCT;
            end
            OPCODE_ALU_IMM: begin
                // funct7 only qualifies the shift encodings; other immediates ignore it
                op = base_op(funct3);
                if (funct3 == F3_SR && funct7 == SUB_FUNCT7) op = OP_SRA;
                else if ((funct3 == F3_SLL || funct3 == F3_SR) && funct7 != ADD_OR_AND_FUNCT7)
                    exc = EXC_ILLEGAL_FUNCT;
            end
            OPCODE_BRANCH: op = OP_BR;
            OPCODE_JUMP:   op = OP_JMP;
            default:       exc = EXC_ILLEGAL_OPCODE;
        endcase
    end
endmodule

// File: rtl/rv_alu.sv
// rv_alu: RV32I+MUL execute-stage ALU with combinational result and sticky exception flag.
//   clk, reset             : clock, synchronous active-high reset (sticky flag only)
//   opcode, funct7, funct3 : instruction fields
//   aluIn1, aluIn2         : operands A and B
//   aluOut, zero           : result and branch equality flag (combinational)
//   exceptionCode          : 0 none, 1 illegal opcode, 2 illegal funct (combinational)
//   excSticky              : registered, set by any exception until reset
module rv_alu
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [6:0]  funct7,
    input  logic [2:0]  funct3,
    input  logic [31:0] aluIn1,
    input  logic [31:0] aluIn2,
    output logic [31:0] aluOut,
    output logic        zero,
    output logic [31:0] exceptionCode,
    output logic        excSticky
);
    alu_op_t     op;
    logic [31:0] result;
    logic [4:0]  shamt;

    rv_alu_decode u_decode (
        .opcode (opcode),
        .funct7 (funct7),
        .funct3 (funct3),
        .op     (op),
        .exc    (exceptionCode)
    );

    assign shamt = aluIn2[4:0];

    always_comb begin
        result = '0;
        case (op)
            OP_SUB:  result = aluIn1 - aluIn2;
            OP_SLL:  result = aluIn1 << shamt;
            OP_SLT:  result = {31'd0, $signed(aluIn1) < $signed(aluIn2)};
            OP_SLTU: result = {31'd0, aluIn1 < aluIn2};
            OP_XOR:  result = aluIn1 ^ aluIn2;
            OP_SRL:  result = aluIn1 >> shamt;
            OP_SRA:  result = $signed(aluIn1) >>> shamt;
            OP_OR:   result = aluIn1 | aluIn2;
            OP_AND:  result = aluIn1 & aluIn2;
            OP_MUL:  result = aluIn1 * aluIn2;
            default: result = aluIn1 + aluIn2;
        endcase
    end

    assign aluOut = (exceptionCode == EXC_NONE) ? result : '0;
    assign zero   = (op == OP_BR) && (aluIn1 == aluIn2);

    always_ff @(posedge clk) begin
        if (reset) excSticky <= 1'b0;
        else if (exceptionCode != EXC_NONE) excSticky <= 1'b1;
    end
endmodule

// File: tb/tb_rv_alu.sv
// tb_rv_alu: directed and randomized self-checking bench for rv_alu.
module tb_rv_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'b0110011;
    logic [6:0]  funct7 = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] aluIn1 = 32'd0;
    logic [31:0] aluIn2 = 32'd0;
    logic [31:0] aluOut;
    logic        zero;
    logic [31:0] exceptionCode;
    logic        excSticky;

    int n_checks = 0;
    int n_fail = 0;
    logic sticky_m = 1'b0;

    rv_alu dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct7        (funct7),
        .funct3        (funct3),
        .aluIn1        (aluIn1),
        .aluIn2        (aluIn2),
        .aluOut        (aluOut),
        .zero          (zero),
        .exceptionCode (exceptionCode),
        .excSticky     (excSticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic straight from the instruction-set rules
    task automatic model(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] out, output logic z, output logic [31:0] exc);
        int sh;
        logic [31:0] basic;
        sh = int'(b[4:0]);
        case (f3)
            3'd0: basic = a + b;
            3'd1: basic = a << sh;
            3'd2: basic = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: basic = (a < b) ? 32'd1 : 32'd0;
            3'd4: basic = a ^ b;
            3'd5: basic = a >> sh;
            3'd6: basic = a | b;
            default: basic = a & b;
        endcase
        out = 32'd0;
        z = 1'b0;
        exc = 32'd0;
        if (op == 7'h33) begin
            if (f7 == 7'h00) out = basic;
            else if (f7 == 7'h20 && f3 == 3'd0) out = a - b;
            else if (f7 == 7'h20 && f3 == 3'd5) out = $signed(a) >>> sh;
            else if (f7 == 7'h01 && f3 == 3'd0) out = a * b;
            else exc = 32'd2;
        end else if (op == 7'h13) begin
            if (f3 == 3'd1 && f7 != 7'h00) exc = 32'd2;
            else if (f3 == 3'd5 && f7 == 7'h20) out = $signed(a) >>> sh;
            else if (f3 == 3'd5 && f7 != 7'h00) exc = 32'd2;
            else out = basic;
        end else if (op == 7'h63) begin
            out = a + b;
            z = (a == b);
        end else if (op == 7'h6F) begin
            out = a + b;
        end else begin
            exc = 32'd1;
        end
        if (exc != 32'd0) out = 32'd0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, then the sticky flag after posedge
    task automatic apply(input string tag, input logic [6:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic rst);
        logic [31:0] e_out, e_exc;
        logic e_z;
        @(negedge clk);
        opcode = op; funct7 = f7; funct3 = f3; aluIn1 = a; aluIn2 = b; reset = rst;
        #1;
        model(op, f7, f3, a, b, e_out, e_z, e_exc);
        check({tag, ".out"}, aluOut, e_out);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, e_z});
        check({tag, ".exc"}, exceptionCode, e_exc);
        @(posedge clk);
        sticky_m = rst ? 1'b0 : (sticky_m | (e_exc != 32'd0));
        #1;
        check({tag, ".sticky"}, {31'd0, excSticky}, {31'd0, sticky_m});
    endtask

    initial begin
        logic [6:0] op_tab [5];
        logic [6:0] f7_tab [4];
        op_tab = '{7'h33, 7'h13, 7'h63, 7'h6F, 7'h33};
        f7_tab = '{7'h00, 7'h20, 7'h01, 7'h00};

        apply("reset", 7'h33, 7'h00, 3'd0, 32'd0, 32'd0, 1'b1);
        check("reset_sticky", {31'd0, excSticky}, 32'd0);

        apply("add", 7'h33, 7'h00, 3'd0, 32'd23, 32'd7, 1'b0);
        check("add_30", aluOut, 32'd30);
        apply("sub", 7'h33, 7'h20, 3'd0, 32'd4, 32'd2, 1'b0);
        check("sub_2", aluOut, 32'd2);
        apply("or", 7'h33, 7'h00, 3'd6, 32'b001011, 32'b010010, 1'b0);
        check("or_val", aluOut, 32'b011011);
        apply("and", 7'h33, 7'h00, 3'd7, 32'b010010, 32'b001110, 1'b0);
        check("and_val", aluOut, 32'b000010);
        apply("br_ne", 7'h63, 7'h00, 3'd0, 32'd2, 32'd10, 1'b0);
        check("br_ne_out", aluOut, 32'd12);
        apply("br_eq", 7'h63, 7'h00, 3'd5, 32'd18, 32'd18, 1'b0);
        check("br_eq_zero", {31'd0, zero}, 32'd1);
        check("br_eq_out", aluOut, 32'd36);
        apply("jump", 7'h6F, 7'h00, 3'd0, 32'd18, 32'd0, 1'b0);
        check("jump_out", aluOut, 32'd18);
        apply("mul", 7'h33, 7'h01, 3'd0, 32'd42, 32'd3, 1'b0);
        check("mul_126", aluOut, 32'd126);
        apply("mul_neg", 7'h33, 7'h01, 3'd0, 32'd42, -32'sd3, 1'b0);
        check("mul_neg_val", aluOut, 32'hFFFFFF82);
        apply("addi", 7'h13, 7'h00, 3'd0, 32'd7, 32'd3, 1'b0);
        check("addi_10", aluOut, 32'd10);
        apply("sra", 7'h33, 7'h20, 3'd5, 32'h80000000, 32'd4, 1'b0);
        check("sra_val", aluOut, 32'hF8000000);
        check("sticky_clear_before_exc", {31'd0, excSticky}, 32'd0);
        apply("bad_op", 7'b1100001, 7'h00, 3'd0, 32'd5, 32'd5, 1'b0);
        check("bad_op_exc", exceptionCode, 32'd1);
        check("sticky_set", {31'd0, excSticky}, 32'd1);
        apply("hold", 7'h33, 7'h00, 3'd0, 32'd1, 32'd1, 1'b0);
        check("sticky_hold", {31'd0, excSticky}, 32'd1);
        apply("rst_clear", 7'h33, 7'h00, 3'd0, 32'd1, 32'd1, 1'b1);
        check("sticky_cleared", {31'd0, excSticky}, 32'd0);
        apply("bad_f", 7'h33, 7'h20, 3'd6, 32'd9, 32'd3, 1'b0);
        check("bad_funct_exc", exceptionCode, 32'd2);
        apply("rst_wins", 7'b1111111, 7'h00, 3'd0, 32'd0, 32'd0, 1'b1);
        check("rst_wins_sticky", {31'd0, excSticky}, 32'd0);
        apply("slli_bad", 7'h13, 7'h20, 3'd1, 32'd1, 32'd3, 1'b0);
        apply("srai", 7'h13, 7'h20, 3'd5, 32'h80000010, 32'd31, 1'b0);
        apply("slt", 7'h33, 7'h00, 3'd2, 32'hFFFFFFFF, 32'd1, 1'b0);
        apply("sltu", 7'h33, 7'h00, 3'd3, 32'hFFFFFFFF, 32'd1, 1'b0);
        apply("add_wrap", 7'h33, 7'h00, 3'd0, 32'hFFFFFFFF, 32'd2, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [6:0] op, f7;
            int sel;
            sel = int'($urandom_range(0, 5));
            op = (sel == 5) ? 7'($urandom) : op_tab[sel];
            sel = int'($urandom_range(0, 4));
            f7 = (sel == 4) ? 7'($urandom) : f7_tab[sel];
            apply("rand", op, f7, 3'($urandom), $urandom, $urandom, ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
